// File: rtl/route_sequencer.sv
// route_sequencer
// Route-level controller for a black-line follower. Walks a programmed table
// of turn codes: enables the follower, presents the turn code for the next
// node, debounces node entry (3'b111) and node exit, and stops on a stop
// code, at end of route, or when the line is lost for too long.
//
// Ports
//   clk, reset        clock; asynchronous active-high reset
//   start, abort      run control (abort wins over start)
//   route_we/waddr/wdata  turn-code table write port (ignored while busy)
//   route_len         number of valid steps, sampled on start, clamped
//   line_sensor       3-bit line sensor, already synchronous to clk
//   robot_enabled     follower enable
//   turn_direction    turn code for the next node (00 S, 01 L, 10 R, 11 stop)
//   busy/done/fault   status levels
//   step_idx          current step pointer
//   node_seen         one-cycle pulse per accepted node
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for start, follower disabled
// FOLLOW   | driving toward the next node, debouncing 3'b111
// AT_NODE  | one-cycle node acknowledge, stop code decision
// CLEAR    | crossing the node, debouncing non-111 before next step
// DONE     | route finished (stop code or end of table)
// FAULT    | line lost for LOST_TIMEOUT samples
module route_sequencer #(
  parameter int MAX_STEPS     = 16,
  parameter int NODE_DEBOUNCE = 4,
  parameter int LOST_TIMEOUT  = 50000,
  localparam int ADDR_W = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              route_we,
  input  logic [ADDR_W-1:0] route_waddr,
  input  logic [1:0]        route_wdata,
  input  logic [ADDR_W:0]   route_len,
  input  logic [2:0]        line_sensor,
  output logic              robot_enabled,
  output logic [1:0]        turn_direction,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [ADDR_W:0]   step_idx,
  output logic              node_seen
);

  localparam int LEN_W  = ADDR_W + 1;
  localparam int DEB    = (NODE_DEBOUNCE < 1) ? 1 : NODE_DEBOUNCE;
  localparam int LOST   = (LOST_TIMEOUT < 1) ? 1 : LOST_TIMEOUT;
  localparam int NCNT_W = $clog2(DEB + 1);
  localparam int LCNT_W = $clog2(LOST + 1);
  localparam logic [NCNT_W-1:0] DEB_C  = NCNT_W'(DEB);
  localparam logic [LCNT_W-1:0] LOST_C = LCNT_W'(LOST);
  localparam logic [LEN_W-1:0]  MAX_C  = LEN_W'(MAX_STEPS);
  localparam logic [1:0]        STOP   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_FOLLOW, S_AT_NODE, S_CLEAR, S_DONE, S_FAULT
  } state_t;

  state_t state, state_d;

  logic [1:0]        route_mem [MAX_STEPS];
  logic [LEN_W-1:0]  len_reg;
  logic [NCNT_W-1:0] node_cnt, node_cnt_inc;
  logic [LCNT_W-1:0] lost_cnt, lost_cnt_inc;
  logic [LEN_W-1:0]  step_inc, len_clamped;
  logic              is_black, is_lost, tracking, idle_like, busy_st, start_acc;
  logic              lost_hit, node_hit, exit_hit, stop_here;
  logic              busy_d, done_d, fault_d, node_seen_d;

  // Datapath decode shared by the FSM and the counters.
  always_comb begin
    is_black     = (line_sensor == 3'b111);
    is_lost      = (line_sensor == 3'b000);
    tracking     = (state == S_FOLLOW) || (state == S_CLEAR);
    idle_like    = (state == S_IDLE) || (state == S_DONE) || (state == S_FAULT);
    busy_st      = tracking || (state == S_AT_NODE);
    start_acc    = idle_like && start && !abort;
    len_clamped  = (route_len > MAX_C) ? MAX_C : route_len;
    step_inc     = step_idx + LEN_W'(1);
    stop_here    = (route_mem[step_idx[ADDR_W-1:0]] == STOP);
    // saturating increments; the hit compares below use the would-be count
    node_cnt_inc = (node_cnt == DEB_C) ? node_cnt : node_cnt + NCNT_W'(1);
    lost_cnt_inc = (lost_cnt == LOST_C) ? lost_cnt : lost_cnt + LCNT_W'(1);
    lost_hit     = tracking && is_lost && (lost_cnt_inc == LOST_C);
    node_hit     = (state == S_FOLLOW) && is_black && (node_cnt_inc == DEB_C);
    exit_hit     = (state == S_CLEAR) && !is_black && (node_cnt_inc == DEB_C);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      robot_enabled <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      fault         <= 1'b0;
      node_seen     <= 1'b0;
    end else begin
      state         <= state_d;
      robot_enabled <= busy_d;
      busy          <= busy_d;
      done          <= done_d;
      fault         <= fault_d;
      node_seen     <= node_seen_d;
    end
  end

  // Next state. Line loss outranks node/exit acceptance; abort outranks all.
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE, S_DONE, S_FAULT:
        if (start) state_d = (len_clamped == '0) ? S_DONE : S_FOLLOW;
      S_FOLLOW:
        if (lost_hit)      state_d = S_FAULT;
        else if (node_hit) state_d = S_AT_NODE;
      S_AT_NODE:
        state_d = stop_here ? S_DONE : S_CLEAR;
      S_CLEAR:
        if (lost_hit)      state_d = S_FAULT;
        else if (exit_hit) state_d = (step_inc == len_reg) ? S_DONE : S_FOLLOW;
      default:
        state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  // Output decode from the upcoming state so outputs are registered.
  always_comb begin
    busy_d      = (state_d == S_FOLLOW) || (state_d == S_AT_NODE) ||
                  (state_d == S_CLEAR);
    done_d      = (state_d == S_DONE);
    fault_d     = (state_d == S_FAULT);
    node_seen_d = (state_d == S_AT_NODE);
  end

  // Step pointer, route length, turn code and debounce/loss counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_idx       <= '0;
      len_reg        <= '0;
      turn_direction <= 2'b00;
      node_cnt       <= '0;
      lost_cnt       <= '0;
    end else if (abort) begin
      turn_direction <= 2'b00;
      node_cnt       <= '0;
      lost_cnt       <= '0;
    end else begin
      case (state)
        S_FOLLOW, S_CLEAR: begin
          lost_cnt <= is_lost ? lost_cnt_inc : '0;
          if (state == S_FOLLOW) node_cnt <= is_black ? node_cnt_inc : '0;
          else                   node_cnt <= !is_black ? node_cnt_inc : '0;
          if (lost_hit) begin
            turn_direction <= 2'b00;
            node_cnt       <= '0;
            lost_cnt       <= '0;
          end else if (node_hit) begin
            node_cnt <= '0;
          end else if (exit_hit) begin
            node_cnt <= '0;
            step_idx <= step_inc;
            turn_direction <= (step_inc == len_reg) ? 2'b00
                                                    : route_mem[step_inc[ADDR_W-1:0]];
          end
        end
        S_AT_NODE: begin
          node_cnt <= '0;
          lost_cnt <= '0;
          if (stop_here) turn_direction <= 2'b00;
        end
        default: begin
          node_cnt <= '0;
          lost_cnt <= '0;
          if (start) begin
            step_idx       <= '0;
            len_reg        <= len_clamped;
            turn_direction <= (len_clamped == '0) ? 2'b00 : route_mem[0];
          end
        end
      endcase
    end
  end

  // Route table: no reset, writes only while not running.
  always_ff @(posedge clk) begin
    if (route_we && !busy_st && !start_acc)
      route_mem[route_waddr] <= route_wdata;
  end

endmodule

// File: tb/tb_route_sequencer.sv
module tb_route_sequencer;
  localparam int MAXS   = 16;
  localparam int DEB    = 4;
  localparam int LOST_T = 40;
  localparam int AW     = 4;

  localparam int P_IDLE = 0, P_FOLLOW = 1, P_NODE = 2, P_LEAVE = 3, P_FIN = 4, P_LOST = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0, abort = 1'b0, route_we = 1'b0;
  logic [AW-1:0] route_waddr = '0;
  logic [1:0]    route_wdata = '0;
  logic [AW:0]   route_len = '0;
  logic [2:0]    line_sensor = 3'b010;
  logic          robot_enabled, busy, done, fault, node_seen;
  logic [1:0]    turn_direction;
  logic [AW:0]   step_idx;

  route_sequencer #(.MAX_STEPS(MAXS), .NODE_DEBOUNCE(DEB), .LOST_TIMEOUT(LOST_T)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .route_we(route_we), .route_waddr(route_waddr), .route_wdata(route_wdata),
    .route_len(route_len), .line_sensor(line_sensor),
    .robot_enabled(robot_enabled), .turn_direction(turn_direction), .busy(busy),
    .done(done), .fault(fault), .step_idx(step_idx), .node_seen(node_seen)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase plus run lengths of sensor classes.
  int ph = P_IDLE;
  int idx = 0, dir = 0, run_len = 0;
  int black = 0, white = 0, lostrun = 0;
  int tbl [MAXS];

  task automatic model_step();
    bit running = (ph == P_FOLLOW) || (ph == P_NODE) || (ph == P_LEAVE);
    bit go = !running && start && !abort;
    bit wen = route_we && !running && !go;
    int wa = int'(route_waddr);
    int wd = int'(route_wdata);
    int s = int'(line_sensor);
    if (abort) begin
      ph = P_IDLE; dir = 0; black = 0; white = 0; lostrun = 0;
    end else begin
      case (ph)
        P_FOLLOW: begin
          lostrun = (s == 0) ? lostrun + 1 : 0;
          black   = (s == 7) ? black + 1 : 0;
          if (lostrun >= LOST_T) begin ph = P_LOST; dir = 0; end
          else if (black >= DEB) begin ph = P_NODE; black = 0; end
        end
        P_NODE: begin
          lostrun = 0;
          if (tbl[idx] == 3) begin ph = P_FIN; dir = 0; end
          else begin ph = P_LEAVE; white = 0; end
        end
        P_LEAVE: begin
          lostrun = (s == 0) ? lostrun + 1 : 0;
          white   = (s != 7) ? white + 1 : 0;
          if (lostrun >= LOST_T) begin ph = P_LOST; dir = 0; end
          else if (white >= DEB) begin
            idx = idx + 1;
            white = 0;
            if (idx == run_len) begin ph = P_FIN; dir = 0; end
            else begin ph = P_FOLLOW; dir = tbl[idx]; black = 0; end
          end
        end
        default: begin
          if (start) begin
            run_len = (int'(route_len) > MAXS) ? MAXS : int'(route_len);
            idx = 0; black = 0; white = 0; lostrun = 0;
            if (run_len == 0) begin ph = P_FIN; dir = 0; end
            else begin ph = P_FOLLOW; dir = tbl[0]; end
          end
        end
      endcase
    end
    if (wen) tbl[wa] = wd;
  endtask

  initial for (int i = 0; i < MAXS; i++) tbl[i] = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ph = P_IDLE; idx = 0; dir = 0; black = 0; white = 0; lostrun = 0;
    end else begin
      model_step();
    end
  end

  // Per-cycle compare against the model, plus logs for directed tests.
  int ns_count = 0;
  int en_count = 0;
  int dir_log[$];

  always @(negedge clk) begin
    if (!reset) begin
      automatic int eb = ((ph == P_FOLLOW) || (ph == P_NODE) || (ph == P_LEAVE)) ? 1 : 0;
      check("m_enabled",   int'(robot_enabled),  eb);
      check("m_busy",      int'(busy),           eb);
      check("m_done",      int'(done),           (ph == P_FIN) ? 1 : 0);
      check("m_fault",     int'(fault),          (ph == P_LOST) ? 1 : 0);
      check("m_node_seen", int'(node_seen),      (ph == P_NODE) ? 1 : 0);
      check("m_step_idx",  int'(step_idx),       idx);
      check("m_turn_dir",  int'(turn_direction), dir);
      if (node_seen) begin
        ns_count++;
        dir_log.push_back(int'(turn_direction));
      end
      if (robot_enabled) en_count++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input int a, input int d);
    route_we = 1'b1;
    route_waddr = AW'(a);
    route_wdata = 2'(d);
    tick();
    route_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic node_pass();
    line_sensor = 3'b111;
    repeat (6) tick();
    line_sensor = 3'b010;
    repeat (20) tick();
  endtask

  task automatic wait_node(input int max_cycles, input string name);
    int n = 0;
    while (!node_seen && n < max_cycles) begin
      tick();
      n++;
    end
    check(name, int'(node_seen), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got t=%0t expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_dir[4];
    int q0, n0, e0;
    int seg_left, seg_val, k;
    int nb[5];
    exp_dir = '{1, 2, 0, 3};
    nb = '{2, 6, 3, 1, 4};

    #1 reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_enabled", int'(robot_enabled), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_fault", int'(fault), 0);
    check("rst_step", int'(step_idx), 0);
    check("rst_turn", int'(turn_direction), 0);

    // Four-node route ending on a stop code.
    wr(0, 1); wr(1, 2); wr(2, 0); wr(3, 3);
    route_len = 5'd4;
    line_sensor = 3'b010;
    pulse_start();
    check("t1_start_busy", int'(busy), 1);
    check("t1_start_en", int'(robot_enabled), 1);
    check("t1_start_turn", int'(turn_direction), 1);
    q0 = dir_log.size();
    n0 = ns_count;
    for (int i = 0; i < 4; i++) node_pass();
    check("t1_pulses", ns_count - n0, 4);
    for (int i = 0; i < 4; i++)
      check("t1_turn_seq", (q0 + i < dir_log.size()) ? dir_log[q0 + i] : -1, exp_dir[i]);
    check("t1_done", int'(done), 1);
    check("t1_en", int'(robot_enabled), 0);
    check("t1_step", int'(step_idx), 3);

    // End of route after the second node exit.
    wr(0, 0); wr(1, 0);
    route_len = 5'd2;
    pulse_start();
    node_pass();
    node_pass();
    check("t2_done", int'(done), 1);
    check("t2_en", int'(robot_enabled), 0);
    check("t2_step", int'(step_idx), 2);

    // Short 111 glitch is not a node.
    pulse_start();
    repeat (2) tick();
    n0 = ns_count;
    line_sensor = 3'b111;
    repeat (DEB - 1) tick();
    line_sensor = 3'b010;
    repeat (10) tick();
    check("t3_no_node", ns_count - n0, 0);
    check("t3_step", int'(step_idx), 0);
    check("t3_busy", int'(busy), 1);

    // Line loss in FOLLOW, then restart.
    line_sensor = 3'b000;
    repeat (LOST_T - 1) tick();
    check("t4_fault_early", int'(fault), 0);
    tick();
    check("t4_fault", int'(fault), 1);
    check("t4_en", int'(robot_enabled), 0);
    line_sensor = 3'b010;
    pulse_start();
    check("t4_restart_fault", int'(fault), 0);
    check("t4_restart_step", int'(step_idx), 0);
    check("t4_restart_busy", int'(busy), 1);

    // Busy write is dropped; abort in CLEAR beats start.
    wr(0, 2);
    line_sensor = 3'b111;
    wait_node(20, "t5_node_timeout");
    line_sensor = 3'b010;
    tick();
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    check("t5_abort_en", int'(robot_enabled), 0);
    check("t5_abort_busy", int'(busy), 0);
    check("t5_abort_done", int'(done), 0);
    pulse_start();
    check("t5_readback_turn", int'(turn_direction), 0);
    check("t5_readback_busy", int'(busy), 1);
    abort = 1'b1; tick(); abort = 1'b0;

    // Zero-length route.
    e0 = en_count;
    route_len = 5'd0;
    pulse_start();
    check("t6_done", int'(done), 1);
    repeat (3) tick();
    check("t6_never_en", en_count - e0, 0);

    // Asynchronous reset mid-route.
    route_len = 5'd2;
    pulse_start();
    check("t7_busy", int'(busy), 1);
    reset = 1'b1;
    #1;
    check("t7_rst_en", int'(robot_enabled), 0);
    check("t7_rst_busy", int'(busy), 0);
    check("t7_rst_turn", int'(turn_direction), 0);
    check("t7_rst_step", int'(step_idx), 0);
    check("t7_rst_done", int'(done), 0);
    check("t7_rst_fault", int'(fault), 0);
    check("t7_rst_ns", int'(node_seen), 0);
    reset = 1'b0;
    tick();

    // Randomized runs checked by the per-cycle model compare.
    seg_left = 0;
    seg_val = 2;
    for (int r = 0; r < 10; r++) begin
      abort = 1'b1; tick(); abort = 1'b0;
      for (int a = 0; a < MAXS; a++) wr(a, $urandom_range(0, 3));
      route_len = 5'($urandom_range(0, 20));
      line_sensor = 3'b010;
      pulse_start();
      for (int c = 0; c < 400; c++) begin
        if (seg_left == 0) begin
          k = $urandom_range(0, 9);
          if (k < 4) begin seg_val = 7; seg_left = $urandom_range(1, 7); end
          else if (k < 8) begin seg_val = nb[$urandom_range(0, 4)]; seg_left = $urandom_range(1, 10); end
          else if (k < 9) begin seg_val = 0; seg_left = $urandom_range(1, 12); end
          else begin seg_val = 0; seg_left = $urandom_range(35, 45); end
        end
        line_sensor = 3'(seg_val);
        seg_left--;
        route_we = ($urandom_range(0, 19) == 0);
        route_waddr = AW'($urandom_range(0, MAXS - 1));
        route_wdata = 2'($urandom_range(0, 3));
        abort = ($urandom_range(0, 299) == 0);
        start = ($urandom_range(0, 39) == 0);
        if ($urandom_range(0, 49) == 0) route_len = 5'($urandom_range(0, 31));
        tick();
      end
      route_we = 1'b0; abort = 1'b0; start = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
